// File: rtl/spawn_scheduler.sv
// Spawn scheduler: tick generator, per-lane pending/cooldown, round-robin spawn offer.
// Optional accepted-spawn counter enabled by defining SPAWN_STATS_EN.
module spawn_scheduler #(
    parameter int NUM_LANES = 8,
    parameter int TICK_DIV  = 16,
    parameter int COOLDOWN  = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_LANES-1:0]         trig,
    input  logic                         spawn_ready,
    output logic                         tick,
    output logic                         spawn_valid,
    output logic [$clog2(NUM_LANES)-1:0] spawn_lane,
    output logic [15:0]                  spawn_count
);

    localparam int LW   = $clog2(NUM_LANES);
    localparam int CNTW = $clog2(TICK_DIV);
    localparam int CW   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [CNTW-1:0] TICK_LAST = CNTW'(TICK_DIV - 1);
    localparam logic [CW-1:0]   COOL_LOAD = CW'(COOLDOWN);
    localparam logic [LW-1:0]   PTR_INIT  = LW'(NUM_LANES - 1);

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    logic [CNTW-1:0]      r_cnt;
    state_t               r_state;
    logic                 r_valid;
    logic [LW-1:0]        r_lane;
    logic [LW-1:0]        r_ptr;
    logic [NUM_LANES-1:0] r_pend;
    logic [CW-1:0]        r_cool [NUM_LANES];

    logic                 w_tick;
    logic                 w_hs;
    logic                 w_found;
    logic [LW-1:0]        w_sel;
    logic [LW-1:0]        w_idx;

    assign w_tick      = (r_cnt == TICK_LAST);
    assign w_hs        = r_valid & spawn_ready;
    assign tick        = w_tick;
    assign spawn_valid = r_valid;
    assign spawn_lane  = r_lane;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // First pending lane searching upward from the lane after the last grant
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            w_idx = LW'((int'(r_ptr) + k) % NUM_LANES);
            if (!w_found && r_pend[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // A grant on the same edge as a tick wins over both set and decrement
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_cool[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_hs && (r_lane == LW'(i))) begin
                    r_pend[i] <= 1'b0;
                    r_cool[i] <= COOL_LOAD;
                end else if (w_tick) begin
                    if (r_cool[i] == '0) begin
                        if (trig[i]) begin
                            r_pend[i] <= 1'b1;
                        end
                    end else begin
                        r_cool[i] <= r_cool[i] - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_lane  <= '0;
            r_ptr   <= PTR_INIT;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_lane  <= w_sel;
                        r_valid <= 1'b1;
                        r_state <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (w_hs) begin
                        r_ptr   <= r_lane;
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef SPAWN_STATS_EN
    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_hs && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign spawn_count = r_count;
`else
    assign spawn_count = '0;
`endif

endmodule

// File: tb/tb_spawn_scheduler.sv
// Scoreboard bench for spawn_scheduler (NUM_LANES=4, TICK_DIV=4, COOLDOWN=2).
// Expected handshakes are queued by the stimulus; a negedge monitor pops and compares.
module tb_spawn_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] trig = 4'b0000;
    logic       spawn_ready = 1'b0;
    logic       tick;
    logic       spawn_valid;
    logic [1:0] spawn_lane;
    logic [15:0] spawn_count;

    typedef struct {
        int lane;
        int hs_at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_cnt = 0;
    logic prev_valid = 1'b0;
    logic prev_hs = 1'b0;
    logic prev_rst = 1'b1;
    logic [1:0] prev_lane = 2'd0;

    spawn_scheduler #(
        .NUM_LANES(4),
        .TICK_DIV (4),
        .COOLDOWN (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .trig       (trig),
        .spawn_ready(spawn_ready),
        .tick       (tick),
        .spawn_valid(spawn_valid),
        .spawn_lane (spawn_lane),
        .spawn_count(spawn_count)
    );

    always #5 clk = ~clk;

    // Edges since reset release; tick is expected while cyc % 4 == 3
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (reset) begin
            exp_cnt  = 0;
            prev_valid = 1'b0;
            prev_hs  = 1'b0;
            prev_rst = 1'b1;
        end else begin
            checks++;
            if (tick !== ((cyc % 4) == 3)) begin
                errors++;
                $display("FAIL tick cyc=%0d got=%b want=%b", cyc, tick, (cyc % 4) == 3);
            end
            checks++;
            if (spawn_count !== 16'(exp_cnt)) begin
                errors++;
                $display("FAIL count cyc=%0d got=%0d want=%0d", cyc, spawn_count, exp_cnt);
            end
            if (prev_valid && !prev_hs && !prev_rst) begin
                checks++;
                if (spawn_valid !== 1'b1 || spawn_lane !== prev_lane) begin
                    errors++;
                    $display("FAIL hold cyc=%0d got v=%b l=%0d want v=1 l=%0d",
                             cyc, spawn_valid, spawn_lane, prev_lane);
                end
            end
            if (spawn_valid && spawn_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_hs edge=%0d got lane=%0d want none", cyc + 1, spawn_lane);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (int'(spawn_lane) != e.lane || (cyc + 1) != e.hs_at) begin
                        errors++;
                        $display("FAIL hs got lane=%0d edge=%0d want lane=%0d edge=%0d",
                                 spawn_lane, cyc + 1, e.lane, e.hs_at);
                    end
                end
`ifdef SPAWN_STATS_EN
                exp_cnt++;
`endif
            end
            prev_valid = spawn_valid;
            prev_hs    = spawn_valid && spawn_ready;
            prev_lane  = spawn_lane;
            prev_rst   = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int n);
        while (cyc < n) step();
    endtask

    task automatic push(input int lane, input int hs_at);
        exp_t e;
        e.lane  = lane;
        e.hs_at = hs_at;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_valid", int'(spawn_valid), 0);
        chk("rst_lane", int'(spawn_lane), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_count", int'(spawn_count), 0);
    endtask

    task automatic check_empty(input string name);
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        // Idle: ticks only, never an offer
        do_reset();
        trig = 4'b0000;
        spawn_ready = 1'b1;
        go(16);
        chk("idle_valid", int'(spawn_valid), 0);
        check_empty("idle_sb");

        // Held trig on lane 2 with cooldown of two ticks
        do_reset();
        trig = 4'b0100;
        spawn_ready = 1'b1;
        push(2, 6);
        push(2, 18);
        push(2, 30);
        go(30);
        trig = 4'b0000;
        go(40);
        check_empty("cool_sb");

        // All lanes on one tick: round-robin 0..3 every second cycle
        do_reset();
        trig = 4'b1111;
        spawn_ready = 1'b1;
        push(0, 6);
        push(1, 8);
        push(2, 10);
        push(3, 12);
        go(4);
        trig = 4'b0000;
        go(24);
        chk("rr_valid_end", int'(spawn_valid), 0);
        check_empty("rr_sb");

        // Backpressure holds lane 0, then lane 1 is offered next
        do_reset();
        trig = 4'b0011;
        spawn_ready = 1'b0;
        go(4);
        trig = 4'b0000;
        go(10);
        chk("bp_valid", int'(spawn_valid), 1);
        chk("bp_lane", int'(spawn_lane), 0);
        go(14);
        spawn_ready = 1'b1;
        push(0, 15);
        go(15);
        spawn_ready = 1'b0;
        chk("bp_gap", int'(spawn_valid), 0);
        go(16);
        chk("bp_next_valid", int'(spawn_valid), 1);
        chk("bp_next_lane", int'(spawn_lane), 1);
        go(18);
        spawn_ready = 1'b1;
        push(1, 19);
        go(19);
        spawn_ready = 1'b0;
        go(28);
        check_empty("bp_sb");

        // Reset mid-offer discards pending requests
        do_reset();
        trig = 4'b0101;
        spawn_ready = 1'b0;
        go(4);
        trig = 4'b0000;
        go(6);
        chk("mid_valid", int'(spawn_valid), 1);
        chk("mid_lane", int'(spawn_lane), 0);
        do_reset();
        spawn_ready = 1'b1;
        go(20);
        chk("mid_after", int'(spawn_valid), 0);
        check_empty("mid_sb");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
